// File: rtl/operand_bus_selector_if.sv
// operand_bus_selector_if: operand sources, immediate-load controls and the B_bus
// valid/ready handshake shared between the selector and its driver/consumer.
interface operand_bus_selector_if #(
    parameter int DATA_W = 8,
    parameter int EXT_W  = 6
);
    logic [DATA_W-1:0] B_reg;
    logic [EXT_W-1:0]  ext_input;
    logic              ext_signed;
    logic [DATA_W-1:0] imm_data;
    logic              imm_load;
    logic [1:0]        B_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] B_bus;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output B_reg, ext_input, ext_signed, imm_data, imm_load, B_sel, in_valid, out_ready,
        input  in_ready, B_bus, out_valid
    );

    modport slave (
        input  B_reg, ext_input, ext_signed, imm_data, imm_load, B_sel, in_valid, out_ready,
        output in_ready, B_bus, out_valid
    );
endinterface

// File: rtl/operand_bus_selector.sv
// operand_bus_selector: registered ALU B-operand mux with a one-entry valid/ready output stage.
// Define EXT_SYNC_EN to pass ext_input through a 2-flop synchroniser before extension.
module operand_bus_selector #(
    parameter int DATA_W = 8,
    parameter int EXT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    operand_bus_selector_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_bus;
    logic [DATA_W-1:0] w_bus_next;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] w_sel_value;
    logic [DATA_W-1:0] w_ext;
    logic [EXT_W-1:0]  w_ext_src;
    logic              w_in_ready;
    logic              w_accept;

    generate
        if (EXT_W < 1 || EXT_W > DATA_W) begin : g_bad_ext_w
            $error("operand_bus_selector: EXT_W must satisfy 1 <= EXT_W <= DATA_W");
        end
    endgenerate

`ifdef EXT_SYNC_EN
    logic [EXT_W-1:0] r_sync1;
    logic [EXT_W-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.ext_input;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ext_src = r_sync2;
`else
    assign w_ext_src = bus.ext_input;
`endif

    // A zero-width replication is illegal, so the full-width case is a plain pass-through.
    generate
        if (EXT_W >= DATA_W) begin : g_ext_pass
            assign w_ext = w_ext_src;
        end else begin : g_ext_widen
            assign w_ext = bus.ext_signed
                         ? {{(DATA_W-EXT_W){w_ext_src[EXT_W-1]}}, w_ext_src}
                         : {{(DATA_W-EXT_W){1'b0}}, w_ext_src};
        end
    endgenerate

    always_comb begin
        w_sel_value = r_bus;
        case (bus.B_sel)
            2'b00:   w_sel_value = bus.B_reg;
            2'b01:   w_sel_value = w_ext;
            2'b10:   w_sel_value = r_imm;
            default: w_sel_value = r_bus;
        endcase
    end

    assign w_in_ready = (r_state == EMPTY) || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // B_bus keeps its value on drain so that sel=11 can re-issue it later.
    always_comb begin
        w_state_next = r_state;
        w_bus_next   = r_bus;
        if (w_accept) begin
            w_state_next = FULL;
            w_bus_next   = w_sel_value;
        end else if (bus.out_ready) begin
            w_state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_bus   <= '0;
        end else begin
            r_state <= w_state_next;
            r_bus   <= w_bus_next;
        end
    end

    // The immediate register loads regardless of handshake or stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imm <= '0;
        end else if (bus.imm_load) begin
            r_imm <= bus.imm_data;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == FULL);
    assign bus.B_bus     = r_bus;
endmodule

// File: tb/tb_operand_bus_selector.sv
// tb_operand_bus_selector: directed vectors feed a scoreboard queue; a negedge monitor
// compares every consumed B_bus value against it.
module tb_operand_bus_selector;
    logic clk;
    logic rst_n;
    int   vecCount;
    int   missCount;
    logic [7:0] expQ[$];

    operand_bus_selector_if #(.DATA_W(8), .EXT_W(6)) busIf ();

    operand_bus_selector #(.DATA_W(8), .EXT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
        vecCount++;
        if (actual !== required) begin
            missCount++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] bReg, input logic extSigned,
                                 input logic [7:0] immData, input logic immLoad, input logic inValid,
                                 input logic outReady, input logic pushExp, input logic [7:0] expVal);
        busIf.B_sel      = sel;
        busIf.B_reg      = bReg;
        busIf.ext_signed = extSigned;
        busIf.imm_data   = immData;
        busIf.imm_load   = immLoad;
        busIf.in_valid   = inValid;
        busIf.out_ready  = outReady;
        if (pushExp) expQ.push_back(expVal);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a transfer happens on every edge where out_valid and out_ready are both high.
    initial begin
        logic [7:0] expVal;
        forever begin
            @(negedge clk);
            if (rst_n && busIf.out_valid && busIf.out_ready) begin
                vecCount++;
                if (expQ.size() == 0) begin
                    missCount++;
                    $display("[TB] FAIL unexpected_output actual=%h required=none", busIf.B_bus);
                end else begin
                    expVal = expQ.pop_front();
                    if (busIf.B_bus !== expVal) begin
                        missCount++;
                        $display("[TB] FAIL scoreboard_bbus actual=%h required=%h", busIf.B_bus, expVal);
                    end
                end
            end
        end
    end

    initial begin
        vecCount  = 0;
        missCount = 0;
        rst_n     = 1'b0;
        busIf.B_reg      = 8'h00;
        busIf.ext_input  = 6'b100001;
        busIf.ext_signed = 1'b0;
        busIf.imm_data   = 8'h00;
        busIf.imm_load   = 1'b0;
        busIf.B_sel      = 2'b00;
        busIf.in_valid   = 1'b0;
        busIf.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_bbus", busIf.B_bus, 8'h00);
        checkOutput("reset_out_valid", {7'b0, busIf.out_valid}, 8'h00);
        checkOutput("reset_in_ready", {7'b0, busIf.in_ready}, 8'h01);

        // Load A5 with the consumer stalled, then reset asynchronously mid-transfer.
        applyStimulus(2'b00, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("held_bbus", busIf.B_bus, 8'hA5);
        checkOutput("held_out_valid", {7'b0, busIf.out_valid}, 8'h01);
        checkOutput("held_in_ready", {7'b0, busIf.in_ready}, 8'h00);
        busIf.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_bbus", busIf.B_bus, 8'h00);
        checkOutput("async_reset_out_valid", {7'b0, busIf.out_valid}, 8'h00);
        checkOutput("async_reset_in_ready", {7'b0, busIf.in_ready}, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(2'b00, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5);
        checkOutput("issue_bbus", busIf.B_bus, 8'hA5);
        checkOutput("issue_out_valid", {7'b0, busIf.out_valid}, 8'h01);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput("stall_bbus", busIf.B_bus, 8'hA5);
            checkOutput("stall_in_ready", {7'b0, busIf.in_ready}, 8'h00);
        end
        applyStimulus(2'b00, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C);

        applyStimulus(2'b01, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h21);
        applyStimulus(2'b01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hE1);

        applyStimulus(2'b00, 8'h00, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(2'b10, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A);
        applyStimulus(2'b10, 8'h00, 1'b0, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A);
        applyStimulus(2'b10, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77);

        applyStimulus(2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("drain_out_valid", {7'b0, busIf.out_valid}, 8'h00);
        checkOutput("drain_bbus", busIf.B_bus, 8'h77);

        applyStimulus(2'b11, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
        checkOutput("reissue_out_valid", {7'b0, busIf.out_valid}, 8'h01);
        applyStimulus(2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        repeat (3) applyStimulus(2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        vecCount++;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
